// File: rtl/l2_evict_write_buffer.sv
// Single-entry eviction write buffer between the L2 memory port and memory.
// Define EWB_WRITE_MERGE_EN to let a same-line writeback overwrite the entry.
module l2_evict_write_buffer #(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 256,
  parameter int IDLE_DRAIN = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              l2_read,
  input  logic              l2_write,
  input  logic [ADDR_W-1:0] l2_address,
  input  logic [LINE_W-1:0] l2_wdata,
  output logic [LINE_W-1:0] l2_rdata,
  output logic              l2_resp,
  output logic              ewb_blocking,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int OFF = 5;
  localparam logic [3:0] IDLE_LAST = 4'(IDLE_DRAIN - 1);

  typedef enum logic [2:0] {
    EMPTY,
    FULL,
    FWD_READ,
    DRAIN,
    RESP
  } state_t;

  state_t            state;
  logic              valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [LINE_W-1:0] buf_data;
  logic [3:0]        idle_cnt;

  logic              match;
  logic              merge_hit;
  logic [ADDR_W-1:0] line_addr;
  logic              unused_ok;

  assign line_addr = {l2_address[ADDR_W-1:OFF], {OFF{1'b0}}};
  assign match     = valid &&
                     (buf_addr[ADDR_W-1:OFF] == l2_address[ADDR_W-1:OFF]);
  assign unused_ok = ^l2_address[OFF-1:0];

`ifdef EWB_WRITE_MERGE_EN
  assign merge_hit = l2_write && !l2_read && match;
`else
  assign merge_hit = 1'b0;
`endif

  assign l2_resp   = (state == RESP);
  assign mem_read  = (state == FWD_READ);
  assign mem_write = (state == DRAIN);
  assign mem_wdata = buf_data;

  // A matching write in FULL is absorbed in place, so it must not block.
  assign ewb_blocking = (state == DRAIN) ||
                        (valid && (state != EMPTY) &&
                         !((state == FULL) && merge_hit));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      valid       <= 1'b0;
      buf_addr    <= '0;
      buf_data    <= '0;
      idle_cnt    <= '0;
      l2_rdata    <= '0;
      mem_address <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          idle_cnt <= '0;
          if (l2_read) begin
            mem_address <= line_addr;
            state       <= FWD_READ;
          end else if (l2_write) begin
            buf_addr <= line_addr;
            buf_data <= l2_wdata;
            valid    <= 1'b1;
            state    <= RESP;
          end
        end
        FULL: begin
          if (l2_read) begin
            idle_cnt <= '0;
            if (match) begin
              l2_rdata <= buf_data;
              state    <= RESP;
            end else begin
              mem_address <= line_addr;
              state       <= FWD_READ;
            end
          end else if (merge_hit) begin
            idle_cnt <= '0;
            buf_data <= l2_wdata;
            state    <= RESP;
          end else if (l2_write) begin
            // Blocked writeback: make room now instead of waiting for idle.
            idle_cnt    <= '0;
            mem_address <= buf_addr;
            state       <= DRAIN;
          end else if (idle_cnt == IDLE_LAST) begin
            idle_cnt    <= '0;
            mem_address <= buf_addr;
            state       <= DRAIN;
          end else begin
            idle_cnt <= idle_cnt + 4'd1;
          end
        end
        FWD_READ: begin
          if (mem_resp) begin
            l2_rdata <= mem_rdata;
            state    <= RESP;
          end
        end
        DRAIN: begin
          if (mem_resp) begin
            valid <= 1'b0;
            state <= EMPTY;
          end
        end
        RESP: begin
          idle_cnt <= '0;
          state    <= valid ? FULL : EMPTY;
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_evict_write_buffer.sv
// Directed bench for l2_evict_write_buffer with a latency-programmable memory.
// Covers forwarding, read-ahead-of-drain, blocking, reset and same-line writes.
module tb_l2_evict_write_buffer;

  localparam int AW = 32;
  localparam int LW = 256;

  localparam logic [LW-1:0] D1 = {8{32'hd1d1_0001}};
  localparam logic [LW-1:0] D2 = {8{32'hd2d2_0002}};
  localparam logic [LW-1:0] D3 = {8{32'hd3d3_0003}};
  localparam logic [LW-1:0] D4 = {8{32'hd4d4_0004}};
  localparam logic [LW-1:0] D5 = {8{32'hd5d5_0005}};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          l2_read, l2_write;
  logic [AW-1:0] l2_address;
  logic [LW-1:0] l2_wdata, l2_rdata;
  logic          l2_resp, ewb_blocking;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata, mem_rdata;
  logic          mem_resp;

  l2_evict_write_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .l2_read      (l2_read),
    .l2_write     (l2_write),
    .l2_address   (l2_address),
    .l2_wdata     (l2_wdata),
    .l2_rdata     (l2_rdata),
    .l2_resp      (l2_resp),
    .ewb_blocking (ewb_blocking),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [LW-1:0] got,
                       input logic [LW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: answers after lat cycles of a held request, logs ops.
  int            lat = 1;
  int            busy = 0;
  logic [LW-1:0] rd_line = '0;
  logic          log_wr[$];
  logic [AW-1:0] log_addr[$];

  initial begin
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_resp = 1'b0;
      if (!rst_n || !(mem_read || mem_write)) begin
        busy = 0;
      end else begin
        busy++;
        if (busy >= lat) begin
          mem_resp  = 1'b1;
          mem_rdata = mem_read ? rd_line : '0;
          log_wr.push_back(mem_write);
          log_addr.push_back(mem_address);
          busy = 0;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the l2_resp cycle.
  task automatic do_req(input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [LW-1:0] d,
                        output int cyc);
    l2_read    = rd;
    l2_write   = wr;
    l2_address = a;
    l2_wdata   = d;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!l2_resp && cyc < 300);
    check("resp_seen", l2_resp, 1);
    l2_read  = 1'b0;
    l2_write = 1'b0;
    @(negedge clk);
    check("resp_once", l2_resp, 0);
  endtask

  task automatic drain_check(input logic [AW-1:0] a, input logic [LW-1:0] d);
    int n = 0;
    while (!mem_write && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_req", mem_write, 1);
    check("drain_addr", mem_address, a);
    check("drain_data", mem_wdata, d);
    check("drain_block", ewb_blocking, 1);
    check("drain_no_rd", mem_read, 0);
    n = 0;
    while (mem_write && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", mem_write, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int s;
    rst_n      = 1'b0;
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_address = '0;
    l2_wdata   = '0;
    repeat (2) @(negedge clk);
    check("rst_resp", l2_resp, 0);
    check("rst_mrd", mem_read, 0);
    check("rst_mwr", mem_write, 0);
    check("rst_block", ewb_blocking, 0);
    check("rst_rdata", l2_rdata, '0);
    check("rst_maddr", mem_address, '0);
    check("rst_mwdata", mem_wdata, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write into EMPTY, then idle drain
    lat = 3;
    do_req(1'b0, 1'b1, 32'h0000_1040, D1, cyc);
    check("wr_lat", cyc, 1);
    check("wr_no_mem", log_wr.size(), 0);
    drain_check(32'h0000_1040, D1);
    check("post_drain_block", ewb_blocking, 0);

    // Forwarded read hit
    do_req(1'b0, 1'b1, 32'h0000_1040, D1, cyc);
    s = log_wr.size();
    do_req(1'b1, 1'b0, 32'h0000_1044, '0, cyc);
    check("fwd_lat", cyc, 1);
    check("fwd_data", l2_rdata, D1);
    check("fwd_no_mem", log_wr.size(), s);

    // Miss read goes ahead of the drain
    lat     = 5;
    rd_line = D2;
    do_req(1'b1, 1'b0, 32'h0000_2000, '0, cyc);
    check("miss_lat", cyc, 6);
    check("miss_data", l2_rdata, D2);
    check("miss_ops", log_wr.size(), s + 1);
    if (log_wr.size() == s + 1) begin
      check("miss_kind", log_wr[s], 0);
      check("miss_addr", log_addr[s], 32'h0000_2000);
    end
    drain_check(32'h0000_1040, D1);

    // Write to a full buffer blocks until the old line drains
    lat = 2;
    do_req(1'b0, 1'b1, 32'h0000_1040, D1, cyc);
    fork
      do_req(1'b0, 1'b1, 32'h0000_3000, D4, cyc);
      drain_check(32'h0000_1040, D1);
    join
    check("blk_lat", cyc, 4);
    drain_check(32'h0000_3000, D4);

    // Same-line write while holding D1
    do_req(1'b0, 1'b1, 32'h0000_1040, D1, cyc);
    s = log_wr.size();
`ifdef EWB_WRITE_MERGE_EN
    check("merge_block", ewb_blocking, 1);
    l2_write   = 1'b1;
    l2_address = 32'h0000_1040;
    #1;
    check("merge_noblock", ewb_blocking, 0);
    do_req(1'b0, 1'b1, 32'h0000_1040, D3, cyc);
    check("merge_lat", cyc, 1);
    check("merge_no_mem", log_wr.size(), s);
`else
    fork
      do_req(1'b0, 1'b1, 32'h0000_1040, D3, cyc);
      drain_check(32'h0000_1040, D1);
    join
    check("same_lat", cyc, 4);
    check("same_ops", log_wr.size(), s + 1);
`endif
    drain_check(32'h0000_1040, D3);

    // Reset in the middle of a drain
    lat = 100;
    do_req(1'b0, 1'b1, 32'h0000_1040, D1, cyc);
    cyc = 0;
    while (!mem_write && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rd_drain_seen", mem_write, 1);
    rst_n = 1'b0;
    #1;
    check("rd_mwr", mem_write, 0);
    check("rd_block", ewb_blocking, 0);
    check("rd_maddr", mem_address, '0);
    @(negedge clk);
    rst_n   = 1'b1;
    lat     = 3;
    rd_line = D5;
    @(negedge clk);
    s = log_wr.size();
    do_req(1'b1, 1'b0, 32'h0000_1040, '0, cyc);
    check("rd_ops", log_wr.size(), s + 1);
    if (log_wr.size() == s + 1) begin
      check("rd_kind", log_wr[s], 0);
      check("rd_addr", log_addr[s], 32'h0000_1040);
    end
    check("rd_data", l2_rdata, D5);
    check("rd_end_block", ewb_blocking, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_evict_write_buffer.md
Name: l2_evict_write_buffer

Overview:
- Single-entry eviction write buffer between the L2 cache controller's physical-memory port and physical memory.
- Acts as the responder to the L2's line read/write requests:
  - absorbs a dirty-line writeback in one cycle;
  - forwards line fills to memory ahead of the pending writeback;
  - drains the buffered line when the port is idle.
- Asserts ewb_blocking whenever the L2 must not issue a new writeback.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 256, cache line width in bits (32-byte line; offset bits [4:0]).
- IDLE_DRAIN, 2, consecutive idle cycles in FULL before a drain starts (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- l2_read  in  1  line read request from L2, held until l2_resp.
- l2_write  in  1  line writeback request from L2, held until l2_resp.
- l2_address  in  ADDR_W  request address; bits [4:0] ignored.
- l2_wdata  in  LINE_W  writeback line.
- l2_rdata  out  LINE_W  read line, valid when l2_resp=1.
- l2_resp  out  1  one-cycle completion pulse.
- ewb_blocking  out  1  buffer cannot accept a writeback.
- mem_read  out  1  read request to physical memory.
- mem_write  out  1  write request to physical memory.
- mem_address  out  ADDR_W  line-aligned memory address ({addr[31:5],5'b0}).
- mem_wdata  out  LINE_W  buffered line.
- mem_rdata  in  LINE_W  memory read data, valid with mem_resp.
- mem_resp  in  1  one-cycle memory completion.

Behaviour:
- Reset (async, rst_n=0):
  - state=EMPTY; valid=0; idle counter=0.
  - All outputs 0: l2_rdata=0, mem_address=0, mem_wdata=0.
  - A mid-operation reset drops the buffered line and any in-flight request. Memory outputs drop immediately.
- States: EMPTY, FULL, FWD_READ, DRAIN, RESP.
- All outputs are registered or state-decoded. mem_* hold stable while the request is asserted.
- Request decode:
  - Line match = valid && buf_addr[31:5]==l2_address[31:5].
  - Request priority: read > write > drain.
  - If l2_read and l2_write are both high, the read is served and the write waits.
- EMPTY:
  - l2_write: capture {address[31:5],5'b0} and wdata; set valid; go RESP. l2_resp rises the next cycle (1-cycle latency).
  - l2_read: go FWD_READ.
- FULL:
  - l2_read with line match: l2_rdata <= buffered line; go RESP (forwarding, 1-cycle latency, no memory access).
  - l2_read with no match: go FWD_READ.
  - l2_write: ewb_blocking=1; the request is held off until the buffer empties via DRAIN.
  - No request: the idle counter increments. When it reaches IDLE_DRAIN, go DRAIN. Any request clears the counter.
- FWD_READ:
  - mem_read=1 and mem_address=line address, held until mem_resp.
  - On mem_resp: l2_rdata <= mem_rdata; go RESP.
  - The buffer is untouched.
- DRAIN:
  - mem_write=1 with mem_address/mem_wdata from the buffer; ewb_blocking=1.
  - On mem_resp: valid=0; go EMPTY.
  - Requests arriving during DRAIN wait; a drain is never aborted.
- RESP:
  - l2_resp=1 for exactly one cycle. Requests are ignored this cycle, because L2 drops its request the cycle after l2_resp.
  - Next state = FULL if valid, else EMPTY.
- ewb_blocking = (state==DRAIN) || (valid && state!=EMPTY). It is 0 in EMPTY and in RESP following a drain.
- No request is lost; each accepted request yields exactly one l2_resp pulse.

Optional Feature:
- EWB_WRITE_MERGE_EN.
- Defined:
  - An l2_write in FULL whose line matches overwrites the buffered data and goes RESP (1-cycle latency).
  - ewb_blocking excludes that case.
- Undefined: a same-line write is treated like any write in FULL (blocks, drains, then accepts).

Test Plan:
- Write A=0x0000_1040, data D1 in EMPTY -> l2_resp 1 cycle later, no mem_write. After 2 idle cycles: mem_write=1, mem_address=0x0000_1040, mem_wdata=D1 until mem_resp; then ewb_blocking=0.
- Buffer holds 0x1040. Read 0x0000_1044 -> l2_rdata=D1, l2_resp next cycle, mem_read never asserted.
- Buffer holds 0x1040. Read 0x0000_2000 -> mem_read precedes the drain. Memory returns D2 after 5 cycles -> l2_rdata=D2. The drain occurs only afterwards.
- Buffer full. Write 0x0000_3000 -> ewb_blocking=1, drain of 0x1040 completes, then 0x3000 is captured and l2_resp pulses once.
- Deassert rst_n during DRAIN -> mem_write=0 and ewb_blocking=0 immediately. The next read 0x1040 goes to memory.
- With EWB_WRITE_MERGE_EN: write 0x1040 D3 while holding D1 -> no mem_write, l2_resp after 1 cycle. A subsequent drain writes D3.
